fifo_rd_stream: RTL
===================

FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

Interface
REQ-001 SHALL have parameter DSIZE, default 8: data word width, equal to the attached asyn_fifo DSIZE.
REQ-002 SHALL have parameter CSIZE, default 16: width of the delivered-word counter.
REQ-003 SHALL have port I_clk, input, 1 bit: single clock, the read clock of the attached FIFO.
REQ-004 SHALL have port I_rst, input, 1 bit: reset; one clock, reset synchronous and active-high.
REQ-005 SHALL have port I_rempty, input, 1 bit: FIFO empty flag.
REQ-006 SHALL have port I_rdata, input, DSIZE bits: FIFO read data, valid one cycle after a pop.
REQ-007 SHALL have port O_rinc, output, 1 bit: FIFO pop request.
REQ-008 SHALL have port O_valid, output, 1 bit: downstream word available.
REQ-009 SHALL have port O_data, output, DSIZE bits: downstream word.
REQ-010 SHALL have port I_ready, input, 1 bit: downstream accepts.
REQ-011 SHALL have port O_rd_cnt, output, CSIZE bits: count of words delivered downstream.

Function
REQ-012 A pop SHALL occur at an edge where O_rinc=1; O_rinc SHALL never assert while I_rempty=1 or I_rst=1.
REQ-013 A word popped at edge k SHALL be sampled from I_rdata at edge k+1 (one-cycle read latency); an internal pend flag SHALL track the in-flight word.
REQ-014 Sampled words SHALL enter a 2-entry buffer (occ 0..2); O_data SHALL equal the oldest entry and O_valid = (occ != 0).
REQ-015 O_rinc SHALL equal ~I_rempty & ((occ+pend < 2) | (O_valid & I_ready)); this path is combinational from I_ready.
REQ-016 A downstream handshake SHALL be O_valid & I_ready at an edge; it SHALL remove the head entry.
REQ-017 Handshake and arriving word at the same edge SHALL leave occ unchanged and preserve order.
REQ-018 occ+pend SHALL never exceed 2; the buffer SHALL never overflow or drop a word.
REQ-019 O_data/O_valid SHALL stay stable while O_valid=1 and I_ready=0.
REQ-020 With I_ready held 1 and the FIFO non-empty, throughput SHALL be one word per cycle after a 2-cycle fill latency (first pop to first O_valid).
REQ-021 O_rd_cnt SHALL increment by 1 per handshake and wrap modulo 2^CSIZE.
REQ-022 Word order at O_data SHALL match FIFO read order exactly.

Reset
REQ-023 While I_rst=1: O_rinc=0, and at the edge O_valid=0, occ=0, pend=0, O_data=0, O_rd_cnt=0.
REQ-024 A word in flight when I_rst asserts SHALL be discarded; the FIFO read side SHALL be reset together with this block.
REQ-025 The first O_rinc after reset SHALL occur no earlier than the first cycle with I_rst=0.

Structure
REQ-026 No shared package; DSIZE and CSIZE are module parameters only.
REQ-027 The block SHALL be flat; no sub-module is natural.
REQ-028 All state SHALL be registered on I_clk; O_rinc SHALL be the only combinational output.

Verification
REQ-029 Reset then push 0x11,0x22,0x33 into FIFO with I_ready=1 -> O_data 0x11,0x22,0x33 on consecutive cycles, O_rd_cnt=3.
REQ-030 I_ready=0 with FIFO holding 5 words -> exactly 2 pops, occ=2, O_data=first word stable; raise I_ready -> remaining 3 words follow in order, 1/cycle.
REQ-031 Random I_ready (50%) over 1000 words, random FIFO fill -> no loss/duplication, O_rinc never with I_rempty=1.
REQ-032 FIFO drains empty mid-stream -> O_valid drops after last word, resumes on refill, order kept.
REQ-033 I_rst pulsed with occ=2 and pend=1 -> next cycle O_valid=0, O_rd_cnt=0, stale words never appear.
REQ-034 CSIZE=4, deliver 17 words -> O_rd_cnt=1 after wrap.

Source files
------------

// File: rtl/fifo_rd_stream_if.sv
// Handshake bundle between an asyn_fifo read port, the stream adapter and its
// downstream consumer; the bench uses it to bundle the adapter's data-path wires.
interface fifo_rd_stream_if #(
    parameter int DSIZE = 8
);
    logic             rempty;
    logic [DSIZE-1:0] rdata;
    logic             rinc;
    logic             valid;
    logic [DSIZE-1:0] data;
    logic             ready;

    modport dut (
        input  rempty,
        input  rdata,
        input  ready,
        output rinc,
        output valid,
        output data
    );

    modport src (
        output rempty,
        output rdata,
        output ready,
        input  rinc,
        input  valid,
        input  data
    );
endinterface

// File: rtl/fifo_rd_stream.sv
// Turns a FIFO read port with one-cycle read latency into a valid/ready stream,
// using a two-entry skid buffer so a full-rate stream survives downstream stalls.
module fifo_rd_stream #(
    parameter int DSIZE = 8,
    parameter int CSIZE = 16
) (
    input  logic             I_clk,
    input  logic             I_rst,
    input  logic             I_rempty,
    input  logic [DSIZE-1:0] I_rdata,
    output logic             O_rinc,
    output logic             O_valid,
    output logic [DSIZE-1:0] O_data,
    input  logic             I_ready,
    output logic [CSIZE-1:0] O_rd_cnt
);

    logic [DSIZE-1:0] buf_reg [2];
    logic [1:0]       occ_reg;
    logic [1:0]       occ_next;
    logic             pend_reg;
    logic [CSIZE-1:0] cnt_reg;
    logic [1:0]       fill;
    logic             hs;
    logic             wr_slot;

    assign O_valid  = (occ_reg != 2'd0);
    assign O_data   = buf_reg[0];
    assign O_rd_cnt = cnt_reg;

    always_comb begin
        hs       = O_valid & I_ready;
        fill     = occ_reg + {1'b0, pend_reg};
        // Pop only when the arriving word is guaranteed a free slot.
        O_rinc   = ~I_rempty & ~I_rst & ((fill < 2'd2) | hs);
        occ_next = occ_reg + {1'b0, pend_reg} - {1'b0, hs};
        // While a word is in flight occ is at most 1, so the landing slot
        // is entry 1 only when entry 0 stays occupied this edge.
        wr_slot  = occ_reg[0] & ~hs;
    end

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            occ_reg    <= 2'd0;
            pend_reg   <= 1'b0;
            cnt_reg    <= '0;
            buf_reg[0] <= '0;
            buf_reg[1] <= '0;
        end else begin
            occ_reg  <= occ_next;
            pend_reg <= O_rinc;
            if (hs) begin
                cnt_reg <= cnt_reg + CSIZE'(1);
            end
            if (pend_reg && !wr_slot) begin
                buf_reg[0] <= I_rdata;
            end else if (hs) begin
                buf_reg[0] <= buf_reg[1];
            end
            if (pend_reg && wr_slot) begin
                buf_reg[1] <= I_rdata;
            end
        end
    end

endmodule
